// File: rtl/demux_stream_if.sv
// Stream demultiplexer bus: one producer-side handshake and N_OUT consumer-side handshakes.
// Port in_bcast exists only when DEMUX_BROADCAST_EN is defined.
interface demux_stream_if #(
   parameter int BUS_WIDTH = 8,
   parameter int SEL_WIDTH = 2
);
   localparam int N_OUT = 1 << SEL_WIDTH;

   logic [BUS_WIDTH-1:0]       in_data;
   logic [SEL_WIDTH-1:0]       in_sel;
   logic                       in_valid;
   logic                       in_ready;
   logic [N_OUT*BUS_WIDTH-1:0] out_data;
   logic [N_OUT-1:0]           out_valid;
   logic [N_OUT-1:0]           out_ready;
`ifdef DEMUX_BROADCAST_EN
   logic                       in_bcast;
`endif

   modport master (
      output in_data, in_sel, in_valid, out_ready,
`ifdef DEMUX_BROADCAST_EN
      output in_bcast,
`endif
      input  in_ready, out_data, out_valid
   );

   modport slave (
      input  in_data, in_sel, in_valid, out_ready,
`ifdef DEMUX_BROADCAST_EN
      input  in_bcast,
`endif
      output in_ready, out_data, out_valid
   );
endinterface

// File: rtl/demux_stream.sv
// Registered 1-to-N stream demultiplexer with a one-word slot per output channel.
// Optional broadcast to all channels is enabled with the DEMUX_BROADCAST_EN macro.
module demux_stream #(
   parameter int BUS_WIDTH = 8,
   parameter int SEL_WIDTH = 2,
   parameter int N_OUT     = 1 << SEL_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   demux_stream_if.slave    bus
);

   logic [N_OUT*BUS_WIDTH-1:0] data_q;
   logic [N_OUT-1:0]           valid_q;
   logic [N_OUT-1:0]           free;
   logic [N_OUT-1:0]           fill;
   logic                       accept_ok;

   // A slot draining on this edge can be refilled on the same edge.
   assign free = ~valid_q | bus.out_ready;

   always_comb begin
      fill      = '0;
      accept_ok = rst_n && free[bus.in_sel];
      fill[bus.in_sel] = bus.in_valid && accept_ok;
`ifdef DEMUX_BROADCAST_EN
      if (bus.in_bcast) begin
         accept_ok = rst_n && (&free);
         fill      = {N_OUT{bus.in_valid && accept_ok}};
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= '0;
      end else begin
         for (int k = 0; k < N_OUT; k++) begin
            if (fill[k]) begin
               data_q[k*BUS_WIDTH +: BUS_WIDTH] <= bus.in_data;
               valid_q[k]                       <= 1'b1;
            end else if (valid_q[k] && bus.out_ready[k]) begin
               valid_q[k] <= 1'b0;
            end
         end
      end
   end

   assign bus.in_ready  = accept_ok;
   assign bus.out_data  = data_q;
   assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream: directed test-plan steps followed by random traffic,
// compared against a per-channel queue model of the stream.
module tb_demux_stream;
   localparam int BW = 4;
   localparam int SW = 2;
   localparam int NO = 1 << SW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   demux_stream_if #(.BUS_WIDTH(BW), .SEL_WIDTH(SW)) bus ();
   demux_stream #(.BUS_WIDTH(BW), .SEL_WIDTH(SW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   // Model: each channel is a queue of words awaiting its consumer; last_word is what an
   // empty channel still shows on its data lines.
   logic [BW-1:0] chq [NO][$];
   logic [BW-1:0] last_word [NO];
   logic          bcast_req = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      for (int k = 0; k < NO; k++) begin
         chq[k].delete();
         last_word[k] = '0;
      end
   endtask

   function automatic logic modelReady();
      logic ok;
      if (!rst_n) return 1'b0;
      if (bcast_req) begin
         ok = 1'b1;
         for (int k = 0; k < NO; k++)
            if (chq[k].size() != 0 && !bus.out_ready[k]) ok = 1'b0;
         return ok;
      end
      return (chq[bus.in_sel].size() == 0) || bus.out_ready[bus.in_sel];
   endfunction

   task automatic applyStimulus(input logic valid, input logic [SW-1:0] sel,
                                input logic [BW-1:0] data, input logic [NO-1:0] ready);
      bus.in_valid  = valid;
      bus.in_sel    = sel;
      bus.in_data   = data;
      bus.out_ready = ready;
`ifdef DEMUX_BROADCAST_EN
      bus.in_bcast  = bcast_req;
`endif
   endtask

   task automatic checkOutput();
      logic [BW-1:0] exp_data;
      for (int k = 0; k < NO; k++) begin
         exp_data = (chq[k].size() != 0) ? chq[k][0] : last_word[k];
         check($sformatf("valid%0d", k), {31'd0, bus.out_valid[k]}, {31'd0, chq[k].size() != 0});
         check($sformatf("data%0d", k), {28'd0, bus.out_data[k*BW +: BW]}, {28'd0, exp_data});
      end
      check("in_ready", {31'd0, bus.in_ready}, {31'd0, modelReady()});
   endtask

   // One clock: check at the falling edge, then apply the handshakes that occur at the rising edge.
   task automatic cycle();
      logic          acc;
      logic [NO-1:0] rdy;
      logic [SW-1:0] sel;
      logic [BW-1:0] data;
      logic          bc;
      @(negedge clk);
      checkOutput();
      acc  = bus.in_valid && modelReady();
      rdy  = bus.out_ready;
      sel  = bus.in_sel;
      data = bus.in_data;
      bc   = bcast_req;
      @(posedge clk);
      for (int k = 0; k < NO; k++)
         if (chq[k].size() != 0 && rdy[k]) void'(chq[k].pop_front());
      if (acc) begin
         for (int k = 0; k < NO; k++) begin
            if (bc || k == int'(sel)) begin
               chq[k].push_back(data);
               last_word[k] = data;
            end
         end
      end
      #1;
   endtask

   initial begin
      modelReset();

      // Reset held with a pending word
      applyStimulus(1'b1, 2'd0, 4'h5, 4'hF);
      #1;
      checkOutput();
      check("rst_valid", {28'd0, bus.out_valid}, 32'h0);
      check("rst_data", {16'd0, bus.out_data}, 32'h0);
      check("rst_ready", {31'd0, bus.in_ready}, 32'h0);
      #6;
      rst_n = 1'b1;
      #1;
      check("release_ready", {31'd0, bus.in_ready}, 32'h1);

      // Unicast sweep
      for (int i = 0; i < NO; i++) begin
         applyStimulus(1'b1, SW'(i), BW'(i), 4'hF);
         cycle();
         check($sformatf("sweep_valid%0d", i), {31'd0, bus.out_valid[i]}, 32'h1);
         check($sformatf("sweep_data%0d", i), {28'd0, bus.out_data[i*BW +: BW]}, i);
      end
      applyStimulus(1'b0, 2'd0, 4'h0, 4'hF);
      cycle();
      cycle();
      check("sweep_drained", {28'd0, bus.out_valid}, 32'h0);

      // Backpressure on channel 2
      applyStimulus(1'b1, 2'd2, 4'hA, 4'b1011);
      cycle();
      check("bp_a_valid", {31'd0, bus.out_valid[2]}, 32'h1);
      applyStimulus(1'b1, 2'd2, 4'hB, 4'b1011);
      #1;
      check("bp_b_blocked", {31'd0, bus.in_ready}, 32'h0);
      repeat (5) begin
         cycle();
         check("bp_a_stable", {28'd0, bus.out_data[2*BW +: BW]}, 32'hA);
      end
      applyStimulus(1'b1, 2'd2, 4'hB, 4'b1111);
      cycle();
      applyStimulus(1'b0, 2'd0, 4'h0, 4'b1011);
      #1;
      check("bp_b_valid", {31'd0, bus.out_valid[2]}, 32'h1);
      check("bp_b_data", {28'd0, bus.out_data[2*BW +: BW]}, 32'hB);

      // Independence: channel 1 stalled, channel 3 still accepts
      applyStimulus(1'b1, 2'd1, 4'h7, 4'b1001);
      cycle();
      applyStimulus(1'b1, 2'd3, 4'h3, 4'b1001);
      #1;
      check("ind_ready", {31'd0, bus.in_ready}, 32'h1);
      cycle();
      check("ind_valid3", {31'd0, bus.out_valid[3]}, 32'h1);
      check("ind_data3", {28'd0, bus.out_data[3*BW +: BW]}, 32'h3);
      check("ind_data1", {28'd0, bus.out_data[1*BW +: BW]}, 32'h7);
      check("ind_valid1", {31'd0, bus.out_valid[1]}, 32'h1);

      // Reset mid-operation with slots full
      applyStimulus(1'b1, 2'd0, 4'h9, 4'b0000);
      cycle();
      applyStimulus(1'b0, 2'd0, 4'h0, 4'hF);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {28'd0, bus.out_valid}, 32'h0);
      check("mid_rst_data", {16'd0, bus.out_data}, 32'h0);
      check("mid_rst_ready", {31'd0, bus.in_ready}, 32'h0);
      modelReset();
      #1;
      rst_n = 1'b1;
      cycle();
      cycle();
      check("post_rst_valid", {28'd0, bus.out_valid}, 32'h0);

`ifdef DEMUX_BROADCAST_EN
      // Broadcast blocked by one stalled channel, then released
      applyStimulus(1'b1, 2'd1, 4'h8, 4'b1101);
      cycle();
      bcast_req = 1'b1;
      applyStimulus(1'b1, 2'd0, 4'h5, 4'b1101);
      #1;
      check("bc_blocked", {31'd0, bus.in_ready}, 32'h0);
      cycle();
      check("bc_partial", {28'd0, bus.out_valid}, 32'h2);
      applyStimulus(1'b1, 2'd0, 4'h5, 4'b1111);
      cycle();
      bcast_req = 1'b0;
      applyStimulus(1'b0, 2'd0, 4'h0, 4'b0000);
      #1;
      check("bc_valid", {28'd0, bus.out_valid}, 32'hF);
      check("bc_data", {16'd0, bus.out_data}, 32'h5555);
      cycle();
`endif

      // Random traffic against the queue model
      for (int n = 0; n < 400; n++) begin
`ifdef DEMUX_BROADCAST_EN
         bcast_req = ($urandom_range(0, 9) == 0);
`endif
         applyStimulus(($urandom_range(0, 3) != 0), SW'($urandom), BW'($urandom),
                       NO'($urandom) | NO'($urandom));
         cycle();
      end
      bcast_req = 1'b0;
      applyStimulus(1'b0, 2'd0, 4'h0, 4'hF);
      cycle();
      cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
